hs4_sync_rx: RTL

HS4_SYNC_RX -- requirements
Module: hs4_sync_rx

---
 rtl/hs4_sync_rx.sv | 115 +++++++++++
 1 files changed

// File: rtl/hs4_sync_rx.sv
// 4-phase bundled-data receiver: synchronizes i_req into clk, completes the
// handshake with a registered o_ack, and queues each token in a small FIFO.
module hs4_sync_rx #(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_req,
  output logic                     o_ack,
  input  logic [DATA_W-1:0]        i_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [DATA_W-1:0]        o_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_LO = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_t                 state_q, state_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [DATA_W-1:0]      mem_q [DEPTH];

  logic req_s;
  logic push;
  logic pop;

  // i_req is only ever observed through the last synchronizer flop
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_req};
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  // Full test uses the registered count, so a same-edge pop never frees a slot early
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s && (count_q != FULL)) begin
          push    = 1'b1;
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!req_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign pop = (count_q != '0) && i_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  assign o_ack   = (state_q == WAIT_LO);
  assign o_valid = (count_q != '0);
  assign o_data  = mem_q[rd_ptr_q];
  assign o_count = count_q;

endmodule
